// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - data, control and status bundle for sync_fifo_prog
// Optional FIFO_ERR_CNT_EN adds the ovf_cnt/udf_cnt rejection counters.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  flush;
  logic                  clr_err;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
`ifdef FIFO_ERR_CNT_EN
  logic [15:0]           ovf_cnt;
  logic [15:0]           udf_cnt;
`endif

  modport master (
    output wr_en, din, rd_en, flush, clr_err, af_thresh, ae_thresh,
`ifdef FIFO_ERR_CNT_EN
    input  ovf_cnt, udf_cnt,
`endif
    input  dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, flush, clr_err, af_thresh, ae_thresh,
`ifdef FIFO_ERR_CNT_EN
    output ovf_cnt, udf_cnt,
`endif
    output dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with count, programmable thresholds, FWFT, flush, sticky errors
// Optional FIFO_ERR_CNT_EN adds saturating overflow/underflow event counters.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_CONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic                  r_overflow, r_underflow;
  logic                  w_full, w_empty;
  logic                  w_wr_acc, w_rd_acc, w_wr_rej, w_rd_rej;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Acceptance is judged on pre-edge state; flush swallows both requests silently.
  assign w_wr_acc = bus.wr_en && !w_full  && !bus.flush;
  assign w_rd_acc = bus.rd_en && !w_empty && !bus.flush;
  assign w_wr_rej = bus.wr_en &&  w_full  && !bus.flush;
  assign w_rd_rej = bus.rd_en &&  w_empty && !bus.flush;

  always_comb begin
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + C_CONE;
        2'b01:   w_count_nxt = r_count - C_CONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.din;
  end

  // A rejection in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_rej)         r_overflow  <= 1'b1;
      else if (bus.clr_err) r_overflow  <= 1'b0;
      if (w_rd_rej)         r_underflow <= 1'b1;
      else if (bus.clr_err) r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_dout <= '0;
        else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
      end
      assign bus.dout = r_dout;
    end
  endgenerate

`ifdef FIFO_ERR_CNT_EN
  logic [15:0] r_ovf_cnt, r_udf_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else begin
      if (bus.clr_err)                          r_ovf_cnt <= {15'd0, w_wr_rej};
      else if (w_wr_rej && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      if (bus.clr_err)                          r_udf_cnt <= {15'd0, w_rd_rej};
      else if (w_rd_rej && r_udf_cnt != 16'hFFFF) r_udf_cnt <= r_udf_cnt + 16'd1;
    end
  end

  assign bus.ovf_cnt = r_ovf_cnt;
  assign bus.udf_cnt = r_udf_cnt;
`endif

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.af_thresh);
  assign bus.almost_empty = (r_count <= bus.ae_thresh);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed bench for sync_fifo_prog, registered and FWFT instances side by side
// Counter checks are compiled in when FIFO_ERR_CNT_EN is defined.
module tb_sync_fifo_prog;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, fl = 1'b0, clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [4:0] af_t = 5'd14, ae_t = 5'd2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
  sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b1 ();

  assign b0.wr_en = wr;  assign b1.wr_en = wr;
  assign b0.rd_en = rd;  assign b1.rd_en = rd;
  assign b0.flush = fl;  assign b1.flush = fl;
  assign b0.clr_err = clr; assign b1.clr_err = clr;
  assign b0.din = din;   assign b1.din = din;
  assign b0.af_thresh = af_t; assign b1.af_thresh = af_t;
  assign b0.ae_thresh = ae_t; assign b1.ae_thresh = ae_t;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_reg (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave));
  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));

  typedef struct {
    logic       wr, rd, fl, clr;
    logic [7:0] din;
    int         cnt;
    logic       ovf, udf;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] q[$];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Flag expectations follow directly from the expected count and the current thresholds.
  task automatic check_state(string nm, int cnt, logic ovf, logic udf, logic [7:0] d0);
    chk({nm, " count"},  int'(b0.count), cnt);
    chk({nm, " full"},   int'(b0.full), int'(cnt == 16));
    chk({nm, " empty"},  int'(b0.empty), int'(cnt == 0));
    chk({nm, " afull"},  int'(b0.almost_full), int'(cnt >= int'(af_t)));
    chk({nm, " aempty"}, int'(b0.almost_empty), int'(cnt <= int'(ae_t)));
    chk({nm, " ovf"},    int'(b0.overflow), int'(ovf));
    chk({nm, " udf"},    int'(b0.underflow), int'(udf));
    chk({nm, " dout"},   int'(b0.dout), int'(d0));
    chk({nm, " count1"}, int'(b1.count), cnt);
    chk({nm, " ovf1"},   int'(b1.overflow), int'(ovf));
    chk({nm, " udf1"},   int'(b1.underflow), int'(udf));
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
    wr = w; rd = r; fl = f; clr = c; din = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
  endtask

  initial begin
    vec_t v;

    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1), i + 1, 1'b0, 1'b0, 8'h00, 8'h01};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 16, 1'b1, 1'b0, 8'h00, 8'h01});
    for (int k = 0; k < 16; k++) begin
      v = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15 - k, 1'b1, 1'b0, 8'(k + 1),
            (k < 15) ? 8'(k + 2) : 8'h00};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 8'h10, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h10, 8'h00});

    #12;
    check_state("reset", 0, 1'b0, 1'b0, 8'h00);
    chk("reset dout1", int'(b1.dout), 0);
    rst_n = 1'b1;
    #2;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].clr, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf, vecs[i].d0);
      chk($sformatf("vec%0d dout1", i), int'(b1.dout), int'(vecs[i].d1));
    end

    // Full with simultaneous read and write: only the read is taken.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    check_state("full_wr_rd", 15, 1'b1, 1'b0, 8'h20);
    chk("full_wr_rd dout1", int'(b1.dout), 'h21);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk($sformatf("drain%0d dout", k), int'(b0.dout), 'h21 + k);
      chk($sformatf("drain%0d count", k), int'(b0.count), 14 - k);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Empty with simultaneous read and write: only the write is taken.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    check_state("empty_wr_rd", 1, 1'b0, 1'b1, 8'h2F);
    chk("empty_wr_rd dout1", int'(b1.dout), 'h77);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("empty_pop", 0, 1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    check_state("fwft_wr", 1, 1'b0, 1'b0, 8'h77);
    chk("fwft_wr dout1", int'(b1.dout), 'hA5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("fwft_pop", 0, 1'b0, 1'b0, 8'hA5);
    chk("fwft_pop dout1", int'(b1.dout), 0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h54);
    check_state("flush", 0, 1'b0, 1'b0, 8'hA5);
    chk("flush dout1", int'(b1.dout), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("post_flush_rd", 0, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check_state("clr_vs_udf", 0, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_state("clr_only", 0, 1'b0, 1'b0, 8'hA5);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
    af_t = 5'd3;  #1; check_state("af_eq", 3, 1'b0, 1'b0, 8'hA5);
    af_t = 5'd4;  #1; check_state("af_above", 3, 1'b0, 1'b0, 8'hA5);
    af_t = 5'd0;  #1; check_state("af_zero", 3, 1'b0, 1'b0, 8'hA5);
    ae_t = 5'd3;  #1; check_state("ae_eq", 3, 1'b0, 1'b0, 8'hA5);
    ae_t = 5'd16; #1; check_state("ae_depth", 3, 1'b0, 1'b0, 8'hA5);
    ae_t = 5'd2;  #1; check_state("ae_below", 3, 1'b0, 1'b0, 8'hA5);
    af_t = 5'd14;
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_state("flush2", 0, 1'b0, 1'b0, 8'hA5);

    // Interleaved traffic at depth 8 carries both pointers across the wrap point.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
      q.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap%0d dout1", i), int'(b1.dout), int'(q[0]));
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      chk($sformatf("wrap%0d dout", i), int'(b0.dout), int'(q.pop_front()));
      chk($sformatf("wrap%0d count", i), int'(b0.count), 8);
      q.push_back(8'(8'hC0 + i));
    end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("wrap_drain dout", int'(b0.dout), int'(q.pop_front()));
    end
    check_state("wrap_end", 0, 1'b0, 1'b0, 8'hE7);

`ifdef FIFO_ERR_CNT_EN
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_cnt sat", int'(b0.ovf_cnt), 'hFFFF);
    chk("udf_cnt", int'(b0.udf_cnt), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_cnt clr", int'(b0.ovf_cnt), 0);
    chk("ovf clr", int'(b0.overflow), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_cnt clr_collide", int'(b0.ovf_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
